jtag_dmi_host: RTL and testbench

JTAG_DMI_HOST -- requirements
Module: jtag_dmi_host

---
 rtl/jtag_dmi_host.sv | 244 ++++++++++++++++++++++++
 tb/tb_jtag_dmi_host.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dmi_host.sv
// JTAG DMI host: drives a RISC-V debug TAP from clk_i, performing one
// DMI access (op scan followed by a result-fetch scan) per request.
// Optional build macro: JTAG_DMI_HOST_RTI_WAIT_EN inserts RtiCycles
// Run-Test/Idle TCKs between the two DR scans of each access.

package jtag_pkg;
    typedef struct packed {
        logic tck;
        logic tms;
        logic trst_n;
        logic tdi;
    } jtag_req_t;

    typedef struct packed {
        logic tdo;
        logic tdo_oe;
    } jtag_rsp_t;
endpackage

module jtag_dmi_host #(
    parameter int                    ClkDiv    = 2,
    parameter int                    IrLength  = 5,
    parameter logic [IrLength-1:0]   DmiIr     = 5'h11,
    parameter int                    RtiCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [6:0]          req_addr_i,
    input  logic [1:0]          req_op_i,
    input  logic [31:0]         req_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_data_o,
    output logic [1:0]          rsp_resp_o,
    output jtag_pkg::jtag_req_t jtag_req_o,
    input  jtag_pkg::jtag_rsp_t jtag_rsp_i
);

    // A DR scan is 3 TMS steps to Shift-DR, 41 shift bits, 2 steps back to idle.
    localparam int DrLen     = 46;
    localparam int IrScanLen = IrLength + 6;
    localparam int SeqA      = (IrScanLen > DrLen) ? IrScanLen : DrLen;
    localparam int SeqW      = (RtiCycles > SeqA) ? RtiCycles : SeqA;
    localparam int CntW      = $clog2(SeqW + 1);
    localparam int DivW      = $clog2(2 * ClkDiv);

    localparam logic [DivW-1:0] DivRise = DivW'(ClkDiv - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(2 * ClkDiv - 1);

    localparam logic [2:0] ST_TAP_RESET = 3'd0;
    localparam logic [2:0] ST_IR_SCAN   = 3'd1;
    localparam logic [2:0] ST_IDLE      = 3'd2;
    localparam logic [2:0] ST_DR_OP     = 3'd3;
    localparam logic [2:0] ST_DR_GET    = 3'd4;
    localparam logic [2:0] ST_RSP       = 3'd5;
`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
    localparam logic [2:0] ST_RTI_WAIT  = 3'd6;
`endif

    logic [2:0]      state;
    logic [6:0]      addr_q;
    logic [1:0]      op_q;
    logic [31:0]     data_q;

    logic            active;
    logic [DivW-1:0] div_cnt;
    logic [CntW-1:0] bits_left;
    logic [SeqW-1:0] tms_sr;
    logic [SeqW-1:0] tdi_sr;
    logic [DrLen-1:0] cap;
    logic            tck_q;
    logic            tms_q;
    logic            tdi_q;
    logic            trst_n_q;

    logic [SeqW-1:0] ld_tms;
    logic [SeqW-1:0] ld_tdi;
    logic [CntW-1:0] ld_len;
    logic [40:0]     dr_field;
    logic            scan_state;
    logic            scan_start;
    logic            scan_done;

    logic            unused_bits;
    assign unused_bits = ^{jtag_rsp_i.tdo_oe, cap[45:37], cap[2:0]};

    assign scan_state = (state == ST_TAP_RESET) || (state == ST_IR_SCAN) ||
`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
                        (state == ST_RTI_WAIT) ||
`endif
                        (state == ST_DR_OP) || (state == ST_DR_GET);
    assign scan_start = scan_state && !active;
    assign scan_done  = active && (div_cnt == DivLast) && (bits_left == CntW'(1));

    assign dr_field = (state == ST_DR_OP) ? {addr_q, data_q, op_q}
                                          : {addr_q, 32'h0, 2'b00};

    // Build the TMS/TDI bit sequences for the scan the current state needs.
    always_comb begin
        ld_tms = '0;
        ld_tdi = '0;
        ld_len = '0;
        case (state)
            ST_TAP_RESET: begin
                ld_tms[4:0] = 5'b11111;
                ld_len      = CntW'(6);
            end
            ST_IR_SCAN: begin
                ld_tms[1:0] = 2'b11;
                for (int i = 0; i < IrLength; i++) begin
                    ld_tdi[4+i] = DmiIr[i];
                end
                ld_tms[3+IrLength] = 1'b1;
                ld_tms[4+IrLength] = 1'b1;
                ld_len             = CntW'(IrScanLen);
            end
            ST_DR_OP, ST_DR_GET: begin
                ld_tms[0]     = 1'b1;
                ld_tms[43]    = 1'b1;
                ld_tms[44]    = 1'b1;
                ld_tdi[43:3]  = dr_field;
                ld_len        = CntW'(DrLen);
            end
`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
            ST_RTI_WAIT: begin
                ld_len = CntW'(RtiCycles);
            end
`endif
            default: begin
            end
        endcase
    end

    // Bit engine: generates TCK, shifts TMS/TDI at period start, samples TDO on the rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active    <= 1'b0;
            div_cnt   <= '0;
            bits_left <= '0;
            tms_sr    <= '0;
            tdi_sr    <= '0;
            cap       <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            trst_n_q  <= 1'b0;
        end else begin
            trst_n_q <= 1'b1;
            if (scan_start) begin
                active    <= 1'b1;
                div_cnt   <= '0;
                bits_left <= ld_len;
                tms_q     <= ld_tms[0];
                tdi_q     <= ld_tdi[0];
                tms_sr    <= ld_tms >> 1;
                tdi_sr    <= ld_tdi >> 1;
            end else if (active) begin
                if (div_cnt == DivLast) begin
                    div_cnt <= '0;
                    tck_q   <= 1'b0;
                    if (bits_left == CntW'(1)) begin
                        active    <= 1'b0;
                        bits_left <= '0;
                        tdi_q     <= 1'b0;
                    end else begin
                        bits_left <= bits_left - CntW'(1);
                        tms_q     <= tms_sr[0];
                        tdi_q     <= tdi_sr[0];
                        tms_sr    <= tms_sr >> 1;
                        tdi_sr    <= tdi_sr >> 1;
                    end
                end else begin
                    div_cnt <= div_cnt + DivW'(1);
                    if (div_cnt == DivRise) begin
                        tck_q <= 1'b1;
                        cap   <= {jtag_rsp_i.tdo, cap[DrLen-1:1]};
                    end
                end
            end
        end
    end

    // Sequencer: TAP reset, IR load, then one op/get scan pair per request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_TAP_RESET;
            addr_q      <= '0;
            op_q        <= '0;
            data_q      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_resp_o  <= '0;
        end else begin
            case (state)
                ST_TAP_RESET: if (scan_done) state <= ST_IR_SCAN;
                ST_IR_SCAN:   if (scan_done) state <= ST_IDLE;
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        addr_q <= req_addr_i;
                        op_q   <= req_op_i;
                        data_q <= req_data_i;
                        state  <= ST_DR_OP;
                    end
                end
                ST_DR_OP: begin
                    if (scan_done) begin
`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
                        state <= (RtiCycles > 0) ? ST_RTI_WAIT : ST_DR_GET;
`else
                        state <= ST_DR_GET;
`endif
                    end
                end
`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
                ST_RTI_WAIT:  if (scan_done) state <= ST_DR_GET;
`endif
                ST_DR_GET: begin
                    if (scan_done) begin
                        rsp_valid_o <= 1'b1;
                        rsp_resp_o  <= cap[4:3];
                        rsp_data_o  <= cap[36:5];
                        state       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_TAP_RESET;
            endcase
        end
    end

    assign req_ready_o       = (state == ST_IDLE) && !rsp_valid_o;
    assign jtag_req_o.tck    = tck_q;
    assign jtag_req_o.tms    = tms_q;
    assign jtag_req_o.trst_n = trst_n_q;
    assign jtag_req_o.tdi    = tdi_q;

endmodule

// File: tb/tb_jtag_dmi_host.sv
// Directed bench for jtag_dmi_host with a behavioural JTAG TAP/DMI model.
module tb_jtag_dmi_host;

    localparam int TAP_TLR = 0,  TAP_RTI = 1,  TAP_SELDR = 2, TAP_CAPDR = 3;
    localparam int TAP_SHDR = 4, TAP_EX1DR = 5, TAP_PDR = 6,  TAP_EX2DR = 7;
    localparam int TAP_UPDR = 8, TAP_SELIR = 9, TAP_CAPIR = 10, TAP_SHIR = 11;
    localparam int TAP_EX1IR = 12, TAP_PIR = 13, TAP_EX2IR = 14, TAP_UPIR = 15;

`ifdef JTAG_DMI_HOST_RTI_WAIT_EN
    localparam int RTI_EXP = 4;
`else
    localparam int RTI_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op, rsp_resp;
    logic [31:0] req_data, rsp_data;
    jtag_pkg::jtag_req_t jreq;
    jtag_pkg::jtag_rsp_t jrsp;

    logic tck, tms, tdi, trst_n;
    logic m_tdo = 1'b0;
    assign tck    = jreq.tck;
    assign tms    = jreq.tms;
    assign tdi    = jreq.tdi;
    assign trst_n = jreq.trst_n;
    assign jrsp.tdo    = m_tdo;
    assign jrsp.tdo_oe = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtag_dmi_host dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_resp_o  (rsp_resp),
        .jtag_req_o  (jreq),
        .jtag_rsp_i  (jrsp)
    );

    // TAP / DMI model
    int          tap_st = TAP_TLR;
    logic [40:0] dr_sr = '0;
    logic [4:0]  ir_sr = '0;
    logic [4:0]  ir_reg = 5'h01;
    logic [40:0] upd_log [0:15];
    int          upd_cnt = 0;
    int          rti_zero = 0;
    int          tck_rises = 0;
    logic [63:0] tms_hist = '0;
    logic [63:0] tdi_hist = '0;
    logic [6:0]  last_addr = '0;
    logic [31:0] mdl_data = '0;
    logic [1:0]  mdl_resp = '0;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TAP_TLR:   return t ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   return t ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: return t ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: return t ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  return t ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: return t ? TAP_UPDR  : TAP_PDR;
            TAP_PDR:   return t ? TAP_EX2DR : TAP_PDR;
            TAP_EX2DR: return t ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  return t ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: return t ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: return t ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  return t ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: return t ? TAP_UPIR  : TAP_PIR;
            TAP_PIR:   return t ? TAP_EX2IR : TAP_PIR;
            TAP_EX2IR: return t ? TAP_UPIR  : TAP_SHIR;
            default:   return t ? TAP_SELDR : TAP_RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= TAP_TLR;
            ir_reg <= 5'h01;
        end else begin
            case (tap_st)
                TAP_CAPDR: dr_sr <= {last_addr, mdl_data, mdl_resp};
                TAP_SHDR:  dr_sr <= {tdi, dr_sr[40:1]};
                TAP_UPDR: begin
                    if (ir_reg == 5'h11) begin
                        upd_log[upd_cnt[3:0]] <= dr_sr;
                        upd_cnt   <= upd_cnt + 1;
                        last_addr <= dr_sr[40:34];
                    end
                end
                TAP_CAPIR: ir_sr  <= 5'h01;
                TAP_SHIR:  ir_sr  <= {tdi, ir_sr[4:1]};
                TAP_UPIR:  ir_reg <= ir_sr;
                TAP_RTI:   if (!tms) rti_zero <= rti_zero + 1;
                default: begin end
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or negedge trst_n) begin
        if (!trst_n) m_tdo <= 1'b0;
        else if (tap_st == TAP_SHDR) m_tdo <= dr_sr[0];
        else if (tap_st == TAP_SHIR) m_tdo <= ir_sr[0];
        else m_tdo <= 1'b0;
    end

    always @(posedge tck) begin
        tck_rises <= tck_rises + 1;
        tms_hist  <= {tms_hist[62:0], tms};
        tdi_hist  <= {tdi_hist[62:0], tdi};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                        output int acc);
        bit ok;
        ok = 1'b0;
        req_addr  = a;
        req_op    = op;
        req_data  = d;
        req_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        acc = tck_rises;
        req_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) timeout(tag);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!req_ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) timeout("ready_after_reset");
    endtask

    initial begin
        int acc, u0, r0, t0, cyc, rel;
        int err_stable, err_rdy, err_tck;

        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_addr = '0;
        req_op = '0;
        req_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_trst_n", trst_n, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_resp", rsp_resp, 0);

        // Bring-up: TAP reset plus IR load
        rst_n = 1'b1;
        rel = tck_rises;
        @(negedge clk);
        check("trst_n_released", trst_n, 1);
        wait_ready(cyc);
        check("init_tck_count", tck_rises - rel, 17);
        check("init_cycles_68_70", (cyc >= 68 && cyc <= 70), 1);
        check("init_tms_seq", tms_hist[16:0], 17'b11111011000000110);
        check("init_tdi_seq", tdi_hist[16:0], 17'b00000000001000100);
        check("init_ir", ir_reg, 5'h11);
        check("idle_tck_low", tck, 0);

        // Read access
        rsp_ready = 1'b1;
        mdl_data = 32'h0040_0382;
        mdl_resp = 2'd0;
        u0 = upd_cnt;
        r0 = rti_zero;
        send(7'h11, 2'd1, 32'h0, acc);
        wait_rsp("rd_rsp");
        check("rd_tck_count", tck_rises - acc, 92 + RTI_EXP);
        check("rd_data", rsp_data, 32'h0040_0382);
        check("rd_resp", rsp_resp, 0);
        @(negedge clk);
        check("rd_one_cycle", rsp_valid, 0);
        check("rd_ready_back", req_ready, 1);
        check("rd_scans", upd_cnt - u0, 2);
        check("rd_op_vec", upd_log[u0 & 15], {7'h11, 32'h0, 2'd1});
        check("rd_get_vec", upd_log[(u0 + 1) & 15], {7'h11, 32'h0, 2'd0});
        check("rd_rti_tcks", rti_zero - r0, RTI_EXP);

        // Write access
        mdl_data = 32'h1234_5678;
        u0 = upd_cnt;
        r0 = rti_zero;
        send(7'h04, 2'd2, 32'hDEAD_BEEF, acc);
        wait_rsp("wr_rsp");
        check("wr_data_captured", rsp_data, 32'h1234_5678);
        check("wr_resp", rsp_resp, 0);
        @(negedge clk);
        check("wr_scans", upd_cnt - u0, 2);
        check("wr_op_vec", upd_log[u0 & 15], {7'h04, 32'hDEAD_BEEF, 2'd2});
        check("wr_get_vec", upd_log[(u0 + 1) & 15], {7'h04, 32'h0, 2'd0});
        check("wr_rti_tcks", rti_zero - r0, RTI_EXP);

        // Busy response passed through, no retry
        mdl_data = 32'hCAFE_0001;
        mdl_resp = 2'd3;
        u0 = upd_cnt;
        send(7'h10, 2'd1, 32'h0, acc);
        wait_rsp("busy_rsp");
        check("busy_resp", rsp_resp, 3);
        check("busy_data", rsp_data, 32'hCAFE_0001);
        @(negedge clk);
        check("busy_ready_after", req_ready, 1);
        t0 = tck_rises;
        repeat (100) @(negedge clk);
        check("busy_no_extra_scans", upd_cnt - u0, 2);
        check("busy_no_extra_tck", tck_rises - t0, 0);

        // Response backpressure with a second request waiting
        mdl_resp = 2'd0;
        mdl_data = 32'h0BAD_F00D;
        rsp_ready = 1'b0;
        u0 = upd_cnt;
        send(7'h20, 2'd1, 32'h0, acc);
        wait_rsp("bp_rsp");
        req_addr = 7'h21;
        req_op = 2'd1;
        req_data = 32'h0;
        req_valid = 1'b1;
        err_stable = 0;
        err_rdy = 0;
        err_tck = 0;
        t0 = tck_rises;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BAD_F00D || rsp_resp !== 2'd0) err_stable++;
            if (req_ready !== 1'b0) err_rdy++;
            if (tck !== 1'b0) err_tck++;
        end
        check("bp_rsp_stable", err_stable, 0);
        check("bp_ready_low", err_rdy, 0);
        check("bp_tck_idle", err_tck, 0);
        check("bp_no_tck_rises", tck_rises - t0, 0);
        check("bp_no_second_accept", upd_cnt - u0, 2);
        mdl_data = 32'h0000_1234;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", rsp_valid, 0);
        u0 = upd_cnt;
        send(7'h21, 2'd1, 32'h0, acc);
        wait_rsp("bp_second_rsp");
        check("bp_second_data", rsp_data, 32'h0000_1234);
        @(negedge clk);
        check("bp_second_addr", upd_log[u0 & 15], {7'h21, 32'h0, 2'd1});

        // Reset in the middle of DR_OP
        u0 = upd_cnt;
        send(7'h05, 2'd1, 32'h0, acc);
        for (int i = 0; i < 2000 && (tck_rises - acc) < 20; i++) @(negedge clk);
        if ((tck_rises - acc) < 20) timeout("mid_scan_bit20");
        #2 rst_n = 1'b0;
        #1;
        check("abort_tck", tck, 0);
        check("abort_tms", tms, 1);
        check("abort_tdi", tdi, 0);
        check("abort_trst_n", trst_n, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_no_update", upd_cnt - u0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = tck_rises;
        wait_ready(cyc);
        check("rerun_tck_count", tck_rises - rel, 17);
        check("rerun_tms_seq", tms_hist[16:0], 17'b11111011000000110);
        check("rerun_ir", ir_reg, 5'h11);
        mdl_data = 32'h5A5A_5A5A;
        send(7'h06, 2'd1, 32'h0, acc);
        wait_rsp("rerun_rsp");
        check("rerun_data", rsp_data, 32'h5A5A_5A5A);
        check("rerun_tck_txn", tck_rises - acc, 92 + RTI_EXP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
